// File: rtl/ysyx_pkg.sv
// Shared state type, AXI constants and helpers for the ysyx bus bridges.
package ysyx_pkg;

  localparam int YSYX_XLEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    DONE
  } lsu_bus_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam logic [2:0] AXI_SIZE_B = 3'd0;
  localparam logic [2:0] AXI_SIZE_H = 3'd1;
  localparam logic [2:0] AXI_SIZE_W = 3'd2;

  // Unrecognised masks fall back to a full word.
  function automatic logic [2:0] strb_to_size(input logic [7:0] strb);
    case (strb)
      8'h01:   return AXI_SIZE_B;
      8'h03:   return AXI_SIZE_H;
      default: return AXI_SIZE_W;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_bus_lane.sv
// Store-path byte-lane placement: moves LSB-aligned data and strobe into the
// lanes selected by the low address bits. Shared with the ifu bridge.
module ysyx_lsu_bus_lane #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      offset,
  input  logic [3:0]      strb_in,
  input  logic [XLEN-1:0] data_in,
  output logic [3:0]      strb_out,
  output logic [XLEN-1:0] data_out
);

  // Strobe bits pushed past lane 3 are discarded; misaligned stores are not supported.
  assign strb_out = strb_in << offset;
  assign data_out = data_in << {offset, 3'b000};

endmodule

// File: rtl/ysyx_lsu_bus.sv
// LSU-to-AXI4 single-beat master bridge. Define YSYX_LSU_BUS_TIMEOUT_EN to
// enable a watchdog that forces an erroring completion after TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | waiting for a load or store request from the LSU
// RD_A  | read address presented, waiting for arready
// RD_D  | rready high, waiting for read data
// WR_AW | write address and data presented, waiting for both handshakes
// WR_B  | bready high, waiting for the write response
// DONE  | result delivered, waiting for the LSU request lines to fall
module ysyx_lsu_bus
  import ysyx_pkg::*;
#(
  parameter int XLEN           = YSYX_XLEN,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            clock,
  input  logic            reset,

  input  logic [XLEN-1:0] lsu_araddr,
  input  logic            lsu_arvalid,
  input  logic [7:0]      lsu_rstrb,
  output logic [XLEN-1:0] bus_rdata,
  output logic            lsu_rvalid,

  input  logic [XLEN-1:0] lsu_awaddr,
  input  logic            lsu_awvalid,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [7:0]      lsu_wstrb,
  input  logic            lsu_wvalid,
  output logic            lsu_wready,
  output logic            bus_err,

  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  output logic [2:0]      arsize,

  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,

  output logic [XLEN-1:0] awaddr,
  output logic            awvalid,
  input  logic            awready,
  output logic [2:0]      awsize,

  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic            wvalid,
  input  logic            wready,

  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  lsu_bus_state_t  state;
  logic [3:0]      lane_wstrb;
  logic [XLEN-1:0] lane_wdata;

  logic unused_wstrb_hi;
  assign unused_wstrb_hi = ^lsu_wstrb[7:4];

`ifdef YSYX_LSU_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  ysyx_lsu_bus_lane #(
    .XLEN(XLEN)
  ) u_lane (
    .offset   (lsu_awaddr[1:0]),
    .strb_in  (lsu_wstrb[3:0]),
    .data_in  (lsu_wdata),
    .strb_out (lane_wstrb),
    .data_out (lane_wdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      araddr     <= '0;
      arsize     <= AXI_SIZE_B;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awsize     <= AXI_SIZE_B;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      bus_rdata  <= '0;
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
      bus_err    <= 1'b0;
`ifdef YSYX_LSU_BUS_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
      bus_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (lsu_arvalid) begin
            araddr  <= lsu_araddr;
            arsize  <= strb_to_size(lsu_rstrb);
            arvalid <= 1'b1;
            state   <= RD_A;
          end else if (lsu_awvalid && lsu_wvalid) begin
            awaddr  <= lsu_awaddr;
            awsize  <= strb_to_size({4'b0000, lsu_wstrb[3:0]});
            wdata   <= lane_wdata;
            wstrb   <= lane_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            state   <= WR_AW;
          end
        end

        RD_A: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_D;
          end
        end

        RD_D: begin
          if (rvalid) begin
            bus_rdata  <= rdata;
            lsu_rvalid <= 1'b1;
            bus_err    <= (rresp != AXI_RESP_OKAY);
            rready     <= 1'b0;
            state      <= DONE;
          end
        end

        WR_AW: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          // A channel counts as done if it already handshook or handshakes now.
          if ((awready || !awvalid) && (wready || !wvalid)) begin
            bready <= 1'b1;
            state  <= WR_B;
          end
        end

        WR_B: begin
          if (bvalid) begin
            lsu_wready <= 1'b1;
            bus_err    <= (bresp != AXI_RESP_OKAY);
            bready     <= 1'b0;
            state      <= DONE;
          end
        end

        DONE: begin
          if (!lsu_arvalid && !lsu_awvalid && !lsu_wvalid) state <= IDLE;
        end

        default: state <= IDLE;
      endcase

`ifdef YSYX_LSU_BUS_TIMEOUT_EN
      if (state == IDLE || state == DONE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        // Give up on the slave: complete with an error and release the bus.
        arvalid <= 1'b0;
        rready  <= 1'b0;
        awvalid <= 1'b0;
        wvalid  <= 1'b0;
        bready  <= 1'b0;
        bus_err <= 1'b1;
        state   <= DONE;
        if (state == RD_A || state == RD_D) begin
          bus_rdata  <= '0;
          lsu_rvalid <= 1'b1;
          lsu_wready <= 1'b0;
        end else begin
          lsu_rvalid <= 1'b0;
          lsu_wready <= 1'b1;
        end
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: doc/ysyx_lsu_bus.md
Name: ysyx_lsu_bus

Overview:
Downstream neighbour of the load/store unit. It turns the LSU's level-held load/store requests into single-beat AXI4 master transactions toward the crossbar/arbiter. It returns a raw, lane-positioned read word with a one-cycle `lsu_rvalid` pulse, and a one-cycle `lsu_wready` pulse on store completion. It owns byte-lane placement of store data and strobes, sizes, and bus-error reporting.

Parameters:
- XLEN, 32, data/address width (`YSYX_XLEN`).
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- lsu_araddr  in  XLEN  load byte address
- lsu_arvalid  in  1  load request, held until served
- lsu_rstrb  in  8  load width mask: 0x01, 0x03 or 0x0f
- bus_rdata  out  XLEN  raw 32-bit word from the bus, not shifted
- lsu_rvalid  out  1  one-cycle pulse, bus_rdata valid
- lsu_awaddr  in  XLEN  store byte address
- lsu_awvalid  in  1  store address request
- lsu_wdata  in  XLEN  store data, LSB-aligned
- lsu_wstrb  in  8  store mask, LSB-aligned; only [3:0] used
- lsu_wvalid  in  1  store data request
- lsu_wready  out  1  one-cycle pulse, store acknowledged
- bus_err  out  1  one-cycle pulse with rvalid/wready when resp != OKAY
- araddr out XLEN, arvalid out 1, arready in 1, arsize out 3
- rdata in XLEN, rresp in 2, rvalid in 1, rready out 1
- awaddr out XLEN, awvalid out 1, awready in 1, awsize out 3
- wdata out XLEN, wstrb out 4, wvalid out 1, wready in 1
- bresp in 2, bvalid in 1, bready out 1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - arvalid, awvalid, wvalid, rready, bready, lsu_rvalid, lsu_wready and bus_err are all 0.
  - bus_rdata is 0.
  - Reset mid-transaction abandons it silently. The interconnect is reset together with this block.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE:
  - lsu_arvalid → latch the address and size, then RD_A.
  - Else lsu_awvalid&&lsu_wvalid → latch the address, data and strobe, then WR_AW.
  - If both requests are present, the load wins. The LSU never raises both.
- RD_A:
  - arvalid=1, address and size held stable.
  - On arready: arvalid drops and the state goes to RD_D.
- RD_D:
  - rready=1.
  - On rvalid: bus_rdata<=rdata, lsu_rvalid pulses the next cycle, bus_err=(rresp!=0), then DONE.
- WR_AW:
  - awvalid and wvalid are raised together. Each drops independently on its own handshake.
  - When both handshakes are complete (either order, same cycle allowed), go to WR_B.
- WR_B:
  - bready=1.
  - On bvalid: lsu_wready pulses the next cycle, bus_err=(bresp!=0), then DONE.
- DONE:
  - Stay until lsu_arvalid, lsu_awvalid and lsu_wvalid are all 0, then IDLE.
  - This prevents double issue while the LSU's held request decays.
  - Latency floor: 1 cycle into a request state, then 3 cycles minimum from request to pulse with zero-wait slaves.
- Sizing:
  - rstrb 0x01→arsize 0, 0x03→1, 0x0f→2. Any other value → 2.
  - awsize is derived the same way from lsu_wstrb[3:0].
- Lane placement (o = addr[1:0]):
  - wstrb = lsu_wstrb[3:0] << o. Bits shifted past bit 3 are dropped; misaligned accesses are unsupported.
  - wdata = lsu_wdata << 8*o.
  - Read data is returned unshifted; the LSU extracts the lane.
- Addresses are passed through unmodified; no word alignment.
- Outputs are driven from registers only. There are no combinational paths from AXI inputs to AXI outputs.

Optional Feature:
- Macro: YSYX_LSU_BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on leaving IDLE and increments in RD_A, RD_D, WR_AW and WR_B.
  - At TIMEOUT_CYCLES-1 the FSM forces completion: bus_rdata=0 for loads, the rvalid or wready pulse plus bus_err pulse, then DONE.
  - All AXI valid/ready outputs are dropped at that point.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Shared package ysyx_pkg holds:
  - the state enum lsu_bus_state_t;
  - constants AXI_RESP_OKAY=2'b00, AXI_SIZE_B/H/W;
  - a function strb_to_size().
- One sub-module, ysyx_lsu_bus_lane: combinational strobe/data shifter for the store path. It is reusable by the ifu bridge.

Test Plan:
1. Read, zero-wait slave: load araddr=0x80000004, rstrb=0x0f, arready=1, rdata=0xdeadbeef next cycle → arsize=2; bus_rdata=0xdeadbeef with a single lsu_rvalid pulse; bus_err=0.
2. Byte store: sb awaddr=0x80000003, wdata=0x000000a5, wstrb=0x1 → wstrb=4'b1000, wdata=0xa5000000, awsize=0, one lsu_wready pulse after bvalid.
3. Split write handshakes: wready 3 cycles before awready, then bvalid after 5 cycles → wvalid drops on its handshake, awvalid holds until arready... awready; exactly one lsu_wready.
4. Held request: lsu_arvalid stays 1 for 4 cycles after lsu_rvalid → no second arvalid until it drops; then a new load issues normally.
5. Error and reset: rresp=2'b10 → bus_err pulses with lsu_rvalid. reset=0 asserted in RD_D → all outputs 0 immediately (asynchronously).
6. Timeout (YSYX_LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): arready never asserted → at cycle 16, lsu_rvalid=1, bus_err=1, bus_rdata=0, arvalid=0.
